// File: rtl/axis_fifo_pkg.sv
// rtl/axis_fifo_pkg.sv - shared types and helpers for the AXI-Stream frame FIFO
// Contents: clog2 for address widths, stored-word layout offsets
// ({tlast, tuser, tdata}), and the encoding of the registered status outputs.
package axis_fifo_pkg;

    // Stored word layout, LSB first: tdata, then tuser, then tlast on top.
    localparam int TDATA_LSB = 0;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    function automatic int tuser_lsb(input int data_width);
        return TDATA_LSB + data_width;
    endfunction

    function automatic int tlast_pos(input int data_width, input int user_width);
        return TDATA_LSB + data_width + user_width;
    endfunction

    typedef enum logic [1:0] {
        ST_NONE,
        ST_GOOD,
        ST_BAD,
        ST_OVF
    } status_e;

endpackage

// File: rtl/axis_fifo_sdp_ram.sv
// rtl/axis_fifo_sdp_ram.sv - simple dual-port RAM with a registered read port
// Ports: clk, rst_n (async, active-low; clears only the read register),
//        wr_en/wr_addr/wr_data write port, rd_en/rd_addr read request,
//        rd_data registered read data (holds while rd_en is low).
module axis_fifo_sdp_ram
    import axis_fifo_pkg::*;
#(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the FIFO output register, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_frame_fifo_v2.sv
// rtl/axis_frame_fifo_v2.sv - store-and-forward AXI4-Stream frame FIFO
// A frame becomes visible on the output only after its tlast beat is accepted
// and the frame is judged good; bad, full-hit and oversize frames are discarded.
// Ports: clk, rst_n (async, active-low); input_axis_* slave stream;
//        output_axis_* master stream; drop_frame level; status_good_frame,
//        status_bad_frame, status_overflow one-cycle pulses; occupancy =
//        committed words not yet read.
// Optional macro AXIS_FRAME_FIFO_V2_STATS_EN adds stat_clr and the saturating
// 16-bit counters stat_good_cnt, stat_bad_cnt, stat_ovf_cnt.
module axis_frame_fifo_v2
    import axis_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int USER_WIDTH     = 1,
    parameter int USER_BAD_BIT   = 0,
    parameter int DROP_WHEN_FULL = 1,
    parameter int DROP_BAD_FRAME = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic [USER_WIDTH-1:0] input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic [USER_WIDTH-1:0] output_axis_tuser,
    output logic                  drop_frame,
    output logic                  status_good_frame,
    output logic                  status_bad_frame,
    output logic                  status_overflow,
    output logic [ADDR_WIDTH:0]   occupancy
`ifdef AXIS_FRAME_FIFO_V2_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [15:0]           stat_good_cnt,
    output logic [15:0]           stat_bad_cnt,
    output logic [15:0]           stat_ovf_cnt
`endif
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int PTR_W     = ADDR_WIDTH + 1;
    localparam int WORD_W    = DATA_WIDTH + USER_WIDTH + 1;
    localparam int TUSER_LSB = tuser_lsb(DATA_WIDTH);
    localparam int TLAST_POS = tlast_pos(DATA_WIDTH, USER_WIDTH);
    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    // wr_ptr: end of committed data; wr_ptr_cur: end of the frame being written.
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_cur, rd_ptr;
    logic              drop_q, out_valid_q;
    logic              full, oversize, empty;
    logic              in_ready, in_fire, beat_drop, mem_we, rd_en;
    logic [WORD_W-1:0] wr_word, rd_word;
    status_e           status_nxt, status_q;

    assign full     = (wr_ptr_cur - rd_ptr) == PTR_DEPTH;
    assign oversize = (wr_ptr_cur - wr_ptr) == PTR_DEPTH;
    assign empty    = (wr_ptr == rd_ptr);

    // An oversize or already-dropping frame is always drained, otherwise a
    // frame longer than the RAM would stall the input forever.
    assign in_ready  = (DROP_WHEN_FULL != 0) ? 1'b1 : (~full | oversize | drop_q);
    assign in_fire   = input_axis_tvalid & in_ready;
    assign beat_drop = drop_q | full | oversize;
    assign mem_we    = in_fire & ~beat_drop;
    assign wr_word   = {input_axis_tlast, input_axis_tuser, input_axis_tdata};

    // The RAM read register is the output register, so a read is simply
    // "output slot free or being emptied this cycle".
    assign rd_en = ~empty & (output_axis_tready | ~out_valid_q);

    always_comb begin
        status_nxt = ST_NONE;
        if (in_fire && input_axis_tlast) begin
            if (beat_drop) begin
                status_nxt = ST_OVF;
            end else if ((DROP_BAD_FRAME != 0) && input_axis_tuser[USER_BAD_BIT]) begin
                status_nxt = ST_BAD;
            end else begin
                status_nxt = ST_GOOD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            wr_ptr_cur  <= '0;
            rd_ptr      <= '0;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            status_q    <= ST_NONE;
        end else begin
            status_q <= status_nxt;
            if (in_fire) begin
                if (mem_we) begin
                    wr_ptr_cur <= wr_ptr_cur + PTR_ONE;
                end
                if (beat_drop) begin
                    drop_q <= 1'b1;
                end
                if (input_axis_tlast) begin
                    drop_q <= 1'b0;
                    if (status_nxt == ST_GOOD) begin
                        wr_ptr <= wr_ptr_cur + PTR_ONE;
                    end else begin
                        // Rewind: the partial frame's words are simply forgotten.
                        wr_ptr_cur <= wr_ptr;
                    end
                end
            end
            if (rd_en) begin
                rd_ptr      <= rd_ptr + PTR_ONE;
                out_valid_q <= 1'b1;
            end else if (output_axis_tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    axis_fifo_sdp_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr_cur[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
        .rd_data (rd_word)
    );

    assign input_axis_tready  = in_ready;
    assign output_axis_tvalid = out_valid_q;
    assign output_axis_tdata  = rd_word[TDATA_LSB +: DATA_WIDTH];
    assign output_axis_tuser  = rd_word[TUSER_LSB +: USER_WIDTH];
    assign output_axis_tlast  = rd_word[TLAST_POS];
    assign drop_frame         = drop_q;
    assign status_good_frame  = (status_q == ST_GOOD);
    assign status_bad_frame   = (status_q == ST_BAD);
    assign status_overflow    = (status_q == ST_OVF);
    assign occupancy          = wr_ptr - rd_ptr;

`ifdef AXIS_FRAME_FIFO_V2_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Counters follow the registered pulses; a clear wins over a coincident pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_good_cnt <= '0;
            stat_bad_cnt  <= '0;
            stat_ovf_cnt  <= '0;
        end else if (stat_clr) begin
            stat_good_cnt <= '0;
            stat_bad_cnt  <= '0;
            stat_ovf_cnt  <= '0;
        end else begin
            if (status_q == ST_GOOD) stat_good_cnt <= sat_inc(stat_good_cnt);
            if (status_q == ST_BAD)  stat_bad_cnt  <= sat_inc(stat_bad_cnt);
            if (status_q == ST_OVF)  stat_ovf_cnt  <= sat_inc(stat_ovf_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_fifo_v2.sv
// tb/tb_axis_frame_fifo_v2.sv - self-checking bench for axis_frame_fifo_v2
// Instance 0 drops on full, instance 1 backpressures; both have DEPTH=4.
module tb_axis_frame_fifo_v2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       i_valid [2], i_last [2], i_user [2], o_ready [2];
    logic [7:0] i_data  [2];
    logic       i_ready [2], o_valid [2], o_last [2], o_user [2];
    logic       drop [2], st_good [2], st_bad [2], st_ovf [2];
    logic [7:0] o_data  [2];
    logic [2:0] occ     [2];
`ifdef AXIS_FRAME_FIFO_V2_STATS_EN
    logic [15:0] sg [2], sb [2], so [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axis_frame_fifo_v2 #(
            .ADDR_WIDTH     (2),
            .DATA_WIDTH     (8),
            .USER_WIDTH     (1),
            .USER_BAD_BIT   (0),
            .DROP_WHEN_FULL ((g == 0) ? 1 : 0),
            .DROP_BAD_FRAME (1)
        ) dut (
            .clk                (clk),
            .rst_n              (rst_n),
            .input_axis_tdata   (i_data[g]),
            .input_axis_tvalid  (i_valid[g]),
            .input_axis_tready  (i_ready[g]),
            .input_axis_tlast   (i_last[g]),
            .input_axis_tuser   (i_user[g]),
            .output_axis_tdata  (o_data[g]),
            .output_axis_tvalid (o_valid[g]),
            .output_axis_tready (o_ready[g]),
            .output_axis_tlast  (o_last[g]),
            .output_axis_tuser  (o_user[g]),
            .drop_frame         (drop[g]),
            .status_good_frame  (st_good[g]),
            .status_bad_frame   (st_bad[g]),
            .status_overflow    (st_ovf[g]),
            .occupancy          (occ[g])
`ifdef AXIS_FRAME_FIFO_V2_STATS_EN
            ,
            .stat_clr           (1'b0),
            .stat_good_cnt      (sg[g]),
            .stat_bad_cnt       (sb[g]),
            .stat_ovf_cnt       (so[g])
`endif
        );
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: got timeout, expected DUT handshake", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input int s, input logic [7:0] d, input logic l, input logic u);
        int t;
        t = 0;
        i_valid[s] = 1'b1; i_data[s] = d; i_last[s] = l; i_user[s] = u;
        while (!i_ready[s] && t < 200) begin
            tick();
            t++;
        end
        if (!i_ready[s]) fail_now($sformatf("dut%0d accept 0x%0h", s, d));
        tick();
        i_valid[s] = 1'b0;
    endtask

    logic [7:0] exp_q [$];

    // Drain one frame with tready high and compare against exp_q.
    task automatic collect_frame(input int s, input string name);
        int idx;
        int t;
        idx = 0;
        t   = 0;
        o_ready[s] = 1'b1;
        while (idx < exp_q.size() && t < 50) begin
            if (o_valid[s]) begin
                chk($sformatf("%s data[%0d]", name, idx), o_data[s], exp_q[idx]);
                chk($sformatf("%s tlast[%0d]", name, idx), o_last[s], (idx == exp_q.size() - 1));
                idx++;
            end
            tick();
            t++;
        end
        if (idx < exp_q.size()) fail_now(name);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       u;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [2:0] est;   // {overflow, bad, good}
        logic [2:0] eocc;
    } vec_t;
    vec_t vt [10];

    logic [8:0] sent_q0 [$];
    logic [8:0] sent_q1 [$];
    logic       prod_done [2];
    logic       rnd_phase;
    int         a_ready_low;

    always @(negedge clk) begin
        if (rnd_phase && !i_ready[0]) a_ready_low++;
    end

    task automatic producer(input int s);
        int         len;
        logic [7:0] fr [4];
        for (int f = 0; f < 100; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                fr[b] = 8'($urandom);
                if (s == 0) sent_q0.push_back({(b == len - 1), fr[b]});
                else        sent_q1.push_back({(b == len - 1), fr[b]});
            end
            for (int b = 0; b < len; b++) send_beat(s, fr[b], (b == len - 1), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        prod_done[s] = 1'b1;
    endtask

    task automatic consumer(input int s);
        logic [8:0] rx [$];
        logic [8:0] fq [$];
        logic [8:0] w, x;
        int         drain;
        logic       matched;
        drain = 0;
        while (drain < 60) begin
            o_ready[s] = prod_done[s] ? 1'b1 : 1'($urandom_range(0, 1));
            if (prod_done[s]) drain++;
            if (o_valid[s] && o_ready[s]) begin
                w = {o_last[s], o_data[s]};
                if (s == 1) begin
                    if (sent_q1.size() == 0) fail_now("rand dut1 unexpected beat");
                    else chk("rand dut1 beat", w, sent_q1.pop_front());
                end else begin
                    rx.push_back(w);
                    if (w[8]) begin
                        // Frames that hit full are skipped; order must hold.
                        matched = 1'b0;
                        while (!matched && sent_q0.size() > 0) begin
                            fq.delete();
                            do begin
                                x = sent_q0.pop_front();
                                fq.push_back(x);
                            end while (!x[8] && sent_q0.size() > 0);
                            matched = (fq.size() == rx.size());
                            for (int k = 0; k < fq.size() && matched; k++)
                                if (fq[k] !== rx[k]) matched = 1'b0;
                        end
                        chk("rand dut0 frame in order", matched, 1'b1);
                        rx.delete();
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rnd_phase = 1'b0;
        a_ready_low = 0;
        for (int s = 0; s < 2; s++) begin
            i_valid[s] = 1'b0; i_last[s] = 1'b0; i_user[s] = 1'b0;
            i_data[s] = 8'h00; o_ready[s] = 1'b0; prod_done[s] = 1'b0;
        end

        //         v     d      l     u     rdy   ev    ed     el    est     occ
        vt[0] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 3'd0};
        vt[1] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 3'd0};
        vt[2] = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'b001, 3'd3};
        vt[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 3'b000, 3'd2};
        vt[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 3'b000, 3'd1};
        vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 3'b000, 3'd0};
        vt[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 3'd0};
        vt[7] = '{1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 3'd0};
        vt[8] = '{1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'b010, 3'd0};
        vt[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 3'd0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset dut%0d tvalid", s), o_valid[s], 1'b0);
            chk($sformatf("reset dut%0d tdata", s), o_data[s], 8'h00);
            chk($sformatf("reset dut%0d occupancy", s), occ[s], 3'd0);
            chk($sformatf("reset dut%0d tready", s), i_ready[s], 1'b1);
            chk($sformatf("reset dut%0d status", s), {st_ovf[s], st_bad[s], st_good[s], drop[s]}, 4'b0000);
        end

        // Good frame then bad frame, cycle by cycle.
        for (int i = 0; i < 10; i++) begin
            i_valid[0] = vt[i].v; i_data[0] = vt[i].d; i_last[0] = vt[i].l;
            i_user[0] = vt[i].u; o_ready[0] = vt[i].rdy;
            tick();
            chk($sformatf("vec%0d tvalid", i), o_valid[0], vt[i].ev);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d tdata", i), o_data[0], vt[i].ed);
                chk($sformatf("vec%0d tlast", i), o_last[0], vt[i].el);
            end
            chk($sformatf("vec%0d status", i), {st_ovf[0], st_bad[0], st_good[0]}, vt[i].est);
            chk($sformatf("vec%0d occupancy", i), occ[0], vt[i].eocc);
            chk($sformatf("vec%0d tready", i), i_ready[0], 1'b1);
        end

        // Drop-when-full: second frame hits full on its tlast beat.
        o_ready[0] = 1'b0;
        send_beat(0, 8'hC1, 1'b0, 1'b0);
        send_beat(0, 8'hC2, 1'b0, 1'b0);
        send_beat(0, 8'hC3, 1'b1, 1'b0);
        chk("full C good pulse", st_good[0], 1'b1);
        send_beat(0, 8'hD1, 1'b0, 1'b0);
        send_beat(0, 8'hD2, 1'b0, 1'b0);
        send_beat(0, 8'hD3, 1'b1, 1'b0);
        chk("full D overflow pulse", {st_ovf[0], st_good[0]}, 2'b10);
        chk("full D drop_frame", drop[0], 1'b0);
        chk("full D occupancy", occ[0], 3'd2);
        exp_q = '{8'hC1, 8'hC2, 8'hC3};
        collect_frame(0, "full C release");
        chk("full D not output", o_valid[0], 1'b0);

        // Backpressure: FIFO full behind a committed frame.
        o_ready[1] = 1'b0;
        send_beat(1, 8'hE1, 1'b0, 1'b0);
        send_beat(1, 8'hE2, 1'b0, 1'b0);
        send_beat(1, 8'hE3, 1'b0, 1'b0);
        send_beat(1, 8'hE4, 1'b1, 1'b0);
        chk("bp E good pulse", st_good[1], 1'b1);
        tick();
        tick();
        chk("bp occupancy after E", occ[1], 3'd3);
        send_beat(1, 8'hF1, 1'b0, 1'b0);
        i_valid[1] = 1'b1; i_data[1] = 8'hF2; i_last[1] = 1'b1;
        chk("bp tready low when full", i_ready[1], 1'b0);
        repeat (4) tick();
        chk("bp tready held low", i_ready[1], 1'b0);
        o_ready[1] = 1'b1;
        tick();
        o_ready[1] = 1'b0;
        chk("bp tready after read", i_ready[1], 1'b1);
        tick();
        i_valid[1] = 1'b0;
        chk("bp F good pulse", st_good[1], 1'b1);
        chk("bp occupancy full", occ[1], 3'd4);
        exp_q = '{8'hE2, 8'hE3, 8'hE4};
        collect_frame(1, "bp E");
        exp_q = '{8'hF1, 8'hF2};
        collect_frame(1, "bp F");
        chk("bp drained", o_valid[1], 1'b0);

        // Oversize frame (6 beats into DEPTH=4) must be drained, not deadlock.
        for (int b = 0; b < 6; b++) begin
            send_beat(1, 8'h40 + 8'(b), (b == 5), 1'b0);
            chk($sformatf("oversize drop_frame beat%0d", b), drop[1], (b == 4));
        end
        chk("oversize overflow pulse", {st_ovf[1], st_good[1]}, 2'b10);
        chk("oversize occupancy", occ[1], 3'd0);
        chk("oversize not output", o_valid[1], 1'b0);
        send_beat(1, 8'h51, 1'b0, 1'b0);
        send_beat(1, 8'h52, 1'b1, 1'b0);
        exp_q = '{8'h51, 8'h52};
        collect_frame(1, "after oversize");

        // Random traffic, both instances concurrently.
        rnd_phase = 1'b1;
        fork
            producer(0);
            producer(1);
            consumer(0);
            consumer(1);
        join
        rnd_phase = 1'b0;
        chk("rand dut1 all delivered", sent_q1.size(), 0);
        chk("rand dut0 tready never low", a_ready_low, 0);

        // Reset mid-frame and mid-read.
        o_ready[0] = 1'b0;
        send_beat(0, 8'h61, 1'b0, 1'b0);
        send_beat(0, 8'h62, 1'b0, 1'b0);
        send_beat(0, 8'h63, 1'b1, 1'b0);
        tick();
        chk("pre-reset tvalid", o_valid[0], 1'b1);
        send_beat(0, 8'h64, 1'b0, 1'b0);
        i_valid[0] = 1'b1; i_data[0] = 8'h65;
        #3 rst_n = 1'b0;
        #1;
        chk("async reset tvalid", o_valid[0], 1'b0);
        chk("async reset tdata", o_data[0], 8'h00);
        chk("async reset occupancy", occ[0], 3'd0);
        chk("async reset flags", {drop[0], st_ovf[0], st_bad[0], st_good[0]}, 4'b0000);
        i_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-reset tvalid", o_valid[0], 1'b0);
        send_beat(0, 8'h71, 1'b0, 1'b0);
        send_beat(0, 8'h72, 1'b1, 1'b0);
        exp_q = '{8'h71, 8'h72};
        collect_frame(0, "post-reset frame");
        chk("post-reset drained", o_valid[0], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
